truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Sequential stimulus-and-check engine for the single-output combinational gate modules in this codebase.
- On start, drives every input minterm in ascending order and waits a settle window on each.
- Samples the gate output once per minterm and compares it against an expected truth-table vector.
- Reports the mismatch count, the first failing minterm, and a pass flag, replacing hand-written $monitor benches with a synthesizable self-checking end.

Parameters:
- N, 2, number of DUT inputs; legal range 1..8.
- EXPECT, 4'b0010, expected truth table, width 2**N; bit m is the expected output for minterm m. The default is a'.b.
- SETTLE, 1, extra cycles each minterm is held before sampling; legal range 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  run request; sampled only in IDLE or DONE.
- dut_in  output  N  minterm driven to the DUT; MSB is DUT input a.
- dut_out  input  1  DUT response.
- busy  output  1  high while a sweep runs.
- done  output  1  level; high from sweep end until next start or reset.
- pass  output  1  done && err_count==0.
- err_count  output  N+1  number of mismatching minterms (max 2**N, so it never saturates).
- first_fail_valid  output  1  at least one mismatch has been recorded.
- first_fail_m  output  N  lowest-index failing minterm; valid only when first_fail_valid=1.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_m=0, settle count=0.
- Reset wins over every other event on the same edge, including a mid-sweep reset. The sweep aborts with no done pulse and no partial results kept.
- States:
  - IDLE: start=1 → RUN; m=0, settle cnt=0, busy=1.
  - RUN: holds dut_in=m for SETTLE+1 cycles. On the edge ending the last cycle:
    - sample dut_out and compare with EXPECT[m];
    - on mismatch, increment err_count; if first_fail_valid=0, set first_fail_m=m and first_fail_valid=1;
    - if m==2**N-1, go to DONE; otherwise m=m+1 and settle cnt=0.
  - DONE: busy=0, done=1, dut_in holds the last minterm. start=1 → RUN with all results cleared on that same edge and done=0.
- Timing: with start accepted at edge k, minterm m is sampled at edge k+(m+1)(SETTLE+1). done rises after edge k+2**N(SETTLE+1). N=2, SETTLE=1 gives 8 cycles.
- start while busy is ignored, with no restart and no error.
- start held high through DONE causes back-to-back sweeps, one idle-free restart per DONE entry.
- Compare is a 4-state inequality (!==) in simulation: X or Z on dut_out counts as a mismatch. Synthesis treats it as XOR.
- Minterm counter width is N+1 so that 2**N-1 is detected without wrap. dut_in is never driven above 2**N-1.
- SETTLE=0: one cycle per minterm; the sample edge is the first edge after dut_in changes.

Decomposition:
- Shared package/header holds:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - constant function NUM_MINTERMS(N)=2**N;
  - default EXPECT vectors for the existing f-series gates (F5_EXPECT=4'b0010, etc.).
- One natural sub-module: tt_settle_timer, a loadable down-counter with parameter SETTLE, inputs clk/reset/load, output expire. It produces the per-minterm sample strobe.
- The FSM, compare logic and result registers stay in the top.

Test Plan:
- Correct a'.b gate (N=2, EXPECT=4'b0010, SETTLE=1), start pulse at edge 0 → dut_in sequence 0,0,1,1,2,2,3,3; done=1 after edge 8; err_count=0; pass=1; first_fail_valid=0.
- Faulty gate s=a&b against EXPECT=4'b0010 → mismatches at m=1 and m=3; err_count=2; first_fail_m=1; pass=0.
- reset asserted at edge 5 of a sweep → next cycle: all outputs at reset values, busy=0, done never rises. New start → full 8-cycle sweep with clean results.
- start re-pulsed at edges 2 and 4 during the sweep → ignored; done still after edge 8. Then start in DONE → err_count and first_fail cleared on the same edge; second sweep completes identically.
- SETTLE=0, N=3, EXPECT=8'b1000_0000 with a 3-input AND → 8-cycle sweep, pass=1. Force dut_out=1'bx at m=2 → err_count=1, first_fail_m=2.

Source files
------------

// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker: FSM encoding, minterm math
// and reference truth tables for the existing f-series gates.
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_t;

    // Bit m of each vector is the gate output for minterm m (MSB input is a).
    localparam logic [3:0] F5_EXPECT   = 4'b0010;
    localparam logic [3:0] AND2_EXPECT = 4'b1000;
    localparam logic [3:0] OR2_EXPECT  = 4'b1110;
    localparam logic [3:0] XOR2_EXPECT = 4'b0110;
    localparam logic [7:0] AND3_EXPECT = 8'b1000_0000;

    function automatic int NUM_MINTERMS(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Per-minterm hold timer: reloaded with SETTLE, counts down to zero and then
// flags that the current minterm has settled long enough to be sampled.
module tt_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= 4'(SETTLE);
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign expire = (cnt == 4'd0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every minterm into a single-output gate, compares the sampled output
// with the expected truth table and keeps mismatch count and first failure.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int N = 2,
    parameter logic [NUM_MINTERMS(N)-1:0] EXPECT = F5_EXPECT,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [N-1:0] dut_in,
    input  logic         dut_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         first_fail_valid,
    output logic [N-1:0] first_fail_m
);

    localparam int         M    = NUM_MINTERMS(N);
    localparam logic [N:0] LAST = (N+1)'(M - 1);

    tt_state_t  state, state_next;
    logic [N:0] m;
    logic       start_ok;
    logic       expire;
    logic       sample;
    logic       last_m;
    logic       mismatch;

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (start_ok || sample),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    start_ok   = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (expire && last_m) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = RUN;
                    start_ok   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sample = (state == RUN) && expire;
    assign last_m = (m == LAST);

    // 4-state compare so an X or Z from the gate is reported as a failure.
    assign mismatch = (dut_out !== EXPECT[m[N-1:0]]);

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            m                <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_m     <= '0;
        end else if (sample) begin
            if (mismatch) begin
                err_count <= err_count + (N+1)'(1);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_m     <= m[N-1:0];
                end
            end
            if (!last_m) begin
                m <= m + (N+1)'(1);
            end
        end
    end

    assign dut_in = m[N-1:0];
    assign pass   = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: two checker instances (N=2/SETTLE=1 and N=3/SETTLE=0)
// driving modelled gates, with the expected minterm sequence kept in queues.
module tb_truth_table_checker;

    localparam logic [3:0] EXP_A = 4'b0010;
    localparam logic [7:0] EXP_B = 8'b1000_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [1:0] dut_in_a;
    logic [2:0] dut_in_b;
    logic       dut_out_a, dut_out_b;
    logic       busy_a, done_a, pass_a, ffv_a;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [2:0] err_a;
    logic [3:0] err_b;
    logic [1:0] ffm_a;
    logic [2:0] ffm_b;

    logic       gate_and_a = 1'b0;
    logic       x_inject   = 1'b0;
    logic       x_val;

    logic [1:0] q_a[$];
    logic [2:0] q_b[$];
    int         exp_err;
    logic       exp_ffv;
    int         exp_ffm;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Gate under test for A: a'.b when correct, a&b when faulty.
    assign dut_out_a = gate_and_a ? (dut_in_a[1] & dut_in_a[0])
                                  : (~dut_in_a[1] & dut_in_a[0]);
    assign dut_out_b = (x_inject && dut_in_b == 3'd2) ? x_val : (&dut_in_b);

    truth_table_checker #(.N(2), .EXPECT(EXP_A), .SETTLE(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .dut_in(dut_in_a),
        .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail_valid(ffv_a), .first_fail_m(ffm_a)
    );

    truth_table_checker #(.N(3), .EXPECT(EXP_B), .SETTLE(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .dut_in(dut_in_b),
        .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail_valid(ffv_b), .first_fail_m(ffm_b)
    );

    // Loads the scoreboard for one A sweep and predicts its results.
    task automatic apply_stimulus_a(input logic faulty);
        logic a, b, o;
        gate_and_a = faulty;
        exp_err = 0; exp_ffv = 1'b0; exp_ffm = 0;
        for (int m = 0; m < 4; m++) begin
            a = m[1]; b = m[0];
            o = faulty ? (a & b) : (~a & b);
            if (o !== EXP_A[m]) begin
                exp_err++;
                if (!exp_ffv) begin exp_ffv = 1'b1; exp_ffm = m; end
            end
            q_a.push_back(2'(m));
            q_a.push_back(2'(m));
        end
    endtask

    task automatic apply_stimulus_b(input logic inject);
        logic o;
        x_inject = inject;
        exp_err = 0; exp_ffv = 1'b0; exp_ffm = 0;
        for (int m = 0; m < 8; m++) begin
            o = (inject && m == 2) ? x_val : (m == 7);
            if (o !== EXP_B[m]) begin
                exp_err++;
                if (!exp_ffv) begin exp_ffv = 1'b1; exp_ffm = m; end
            end
            q_b.push_back(3'(m));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, done_a, pass_a, ffv_a, dut_in_a, err_a, ffm_a} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_a: got %b required 0", {busy_a, done_a, pass_a, ffv_a, dut_in_a, err_a, ffm_a});
        end
        checks++;
        if ({busy_b, done_b, pass_b, ffv_b, dut_in_b, err_b, ffm_b} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_b: got %b required 0", {busy_b, done_b, pass_b, ffv_b, dut_in_b, err_b, ffm_b});
        end
        reset = 1'b0;
    endtask

    task automatic test_sweep_a(input logic faulty);
        logic [1:0] exp_in;
        apply_stimulus_a(faulty);
        start_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            exp_in = q_a.pop_front();
            checks++;
            if (dut_in_a !== exp_in || busy_a !== 1'b1 || done_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sweep_a cyc%0d: got in=%0d busy=%b done=%b required in=%0d busy=1 done=0", i, dut_in_a, busy_a, done_a, exp_in);
            end
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || err_a !== 3'(exp_err) || pass_a !== (exp_err == 0)) begin
            errors++;
            $display("[TB] FAIL result_a: got done=%b busy=%b err=%0d pass=%b required done=1 busy=0 err=%0d", done_a, busy_a, err_a, pass_a, exp_err);
        end
        checks++;
        if (ffv_a !== exp_ffv || (exp_ffv && ffm_a !== 2'(exp_ffm))) begin
            errors++;
            $display("[TB] FAIL first_fail_a: got valid=%b m=%0d required valid=%b m=%0d", ffv_a, ffm_a, exp_ffv, exp_ffm);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [1:0] exp_in;
        apply_stimulus_a(1'b1);
        start_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            exp_in = q_a.pop_front();
            checks++;
            if (dut_in_a !== exp_in) begin
                errors++;
                $display("[TB] FAIL pre_reset_in cyc%0d: got %0d required %0d", i, dut_in_a, exp_in);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q_a.delete();
        checks++;
        if ({busy_a, done_a, pass_a, ffv_a, dut_in_a, err_a, ffm_a} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %b required 0", {busy_a, done_a, pass_a, ffv_a, dut_in_a, err_a, ffm_a});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (done_a !== 1'b0 || busy_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_after_reset cyc%0d: got done=%b busy=%b required 0 0", i, done_a, busy_a);
            end
        end
        test_sweep_a(1'b0);
    endtask

    task automatic test_restart_ignored();
        logic [1:0] exp_in;
        apply_stimulus_a(1'b1);
        start_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start_a = (i == 1 || i == 3);
            if (i == 0) begin
                checks++;
                if (err_a !== 3'd0 || ffv_a !== 1'b0 || done_a !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL restart_clear: got err=%0d ffv=%b done=%b required 0 0 0", err_a, ffv_a, done_a);
                end
            end
            exp_in = q_a.pop_front();
            checks++;
            if (dut_in_a !== exp_in || busy_a !== 1'b1) begin
                errors++;
                $display("[TB] FAIL restart_in cyc%0d: got in=%0d busy=%b required in=%0d busy=1", i, dut_in_a, busy_a, exp_in);
            end
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || err_a !== 3'(exp_err) || ffm_a !== 2'(exp_ffm)) begin
            errors++;
            $display("[TB] FAIL restart_result: got done=%b err=%0d ffm=%0d required done=1 err=%0d ffm=%0d", done_a, err_a, ffm_a, exp_err, exp_ffm);
        end
    endtask

    task automatic test_back_to_back();
        apply_stimulus_a(1'b0);
        q_a.delete();
        start_a = 1'b1;
        repeat (9) @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_first_done: got done=%b pass=%b required 1 1", done_a, pass_a);
        end
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || done_a !== 1'b0 || dut_in_a !== 2'd0) begin
            errors++;
            $display("[TB] FAIL b2b_restart: got busy=%b done=%b in=%0d required 1 0 0", busy_a, done_a, dut_in_a);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second_done: got done=%b pass=%b required 1 1", done_a, pass_a);
        end
    endtask

    task automatic test_settle0_b(input logic inject);
        logic [2:0] exp_in;
        apply_stimulus_b(inject);
        start_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start_b = 1'b0;
            exp_in = q_b.pop_front();
            checks++;
            if (dut_in_b !== exp_in || busy_b !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sweep_b cyc%0d: got in=%0d busy=%b required in=%0d busy=1", i, dut_in_b, busy_b, exp_in);
            end
        end
        @(negedge clk);
        checks++;
        if (done_b !== 1'b1 || err_b !== 4'(exp_err) || pass_b !== (exp_err == 0)) begin
            errors++;
            $display("[TB] FAIL result_b: got done=%b err=%0d pass=%b required done=1 err=%0d", done_b, err_b, pass_b, exp_err);
        end
        checks++;
        if (ffv_b !== exp_ffv || (exp_ffv && ffm_b !== 3'(exp_ffm))) begin
            errors++;
            $display("[TB] FAIL first_fail_b: got valid=%b m=%0d required valid=%b m=%0d", ffv_b, ffm_b, exp_ffv, exp_ffm);
        end
        x_inject = 1'b0;
    endtask

    initial begin
        x_val = 1'bx;
        test_reset();
        @(negedge clk);
        test_sweep_a(1'b0);
        test_sweep_a(1'b1);
        test_reset_mid_sweep();
        test_sweep_a(1'b1);
        test_restart_ignored();
        test_back_to_back();
        test_settle0_b(1'b0);
        test_settle0_b(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
